// File: rtl/expipe_pkg.sv
// Shared types for the frontend redirect arbiter.
//   redir_src_t       : which requester a redirect came from
//   redir_arb_state_t : arbiter FSM states
package expipe_pkg;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_BU,
        SRC_CU
    } redir_src_t;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        STALL
    } redir_arb_state_t;

endpackage

// File: rtl/fe_redirect_arb_if.sv
// Redirect bus between the requesters (branch units, commit unit), the
// arbiter and the frontend pcgen.
//   master : environment side (drives requests and pcgen ready)
//   slave  : arbiter side (drives request readies and the pcgen redirect)
// Signals:
//   bu_valid_i / bu_rob_idx_i / bu_pc_i / bu_ready_o : branch-unit requests
//   cu_valid_i / cu_pc_i / cu_ready_o                : commit-unit request
//   fe_pcgen_valid_o / fe_pcgen_pc_o / fe_pcgen_ready_i : redirect to pcgen
interface fe_redirect_arb_if #(
    parameter int NUM_BU    = 2,
    parameter int ROB_IDX_W = 5,
    parameter int XLEN      = 64
) ();
    logic [NUM_BU-1:0]           bu_valid_i;
    logic [NUM_BU*ROB_IDX_W-1:0] bu_rob_idx_i;
    logic [NUM_BU*XLEN-1:0]      bu_pc_i;
    logic [NUM_BU-1:0]           bu_ready_o;
    logic                        cu_valid_i;
    logic [XLEN-1:0]             cu_pc_i;
    logic                        cu_ready_o;
    logic                        fe_pcgen_valid_o;
    logic [XLEN-1:0]             fe_pcgen_pc_o;
    logic                        fe_pcgen_ready_i;

    modport master (
        output bu_valid_i, bu_rob_idx_i, bu_pc_i, cu_valid_i, cu_pc_i, fe_pcgen_ready_i,
        input  bu_ready_o, cu_ready_o, fe_pcgen_valid_o, fe_pcgen_pc_o
    );

    modport slave (
        input  bu_valid_i, bu_rob_idx_i, bu_pc_i, cu_valid_i, cu_pc_i, fe_pcgen_ready_i,
        output bu_ready_o, cu_ready_o, fe_pcgen_valid_o, fe_pcgen_pc_o
    );
endinterface

// File: rtl/oldest_req_sel.sv
// Combinational oldest-request selector.
// Age of a branch-unit request is its ROB index minus the ROB head, modulo
// the ROB depth; smaller is older. The commit request is always oldest.
// Equal-age branch units resolve to the lowest port index.
// Ports:
//   rob_head_idx_i : current ROB head
//   bu_valid_i     : branch-unit request valids
//   bu_rob_idx_i   : packed ROB index per branch unit
//   cu_valid_i     : commit-unit request valid
//   src_o          : winner source (SRC_NONE if nothing valid)
//   bu_gnt_o       : one-hot grant to the winning branch unit (0 if CU/none)
//   win_idx_o      : winning branch-unit port index
//   win_age_o      : winner's age (0 for the commit unit)
module oldest_req_sel
    import expipe_pkg::*;
#(
    parameter int  NUM_BU    = 2,
    parameter int  ROB_IDX_W = 5,
    localparam int IDX_W     = (NUM_BU > 1) ? $clog2(NUM_BU) : 1
) (
    input  logic [ROB_IDX_W-1:0]        rob_head_idx_i,
    input  logic [NUM_BU-1:0]           bu_valid_i,
    input  logic [NUM_BU*ROB_IDX_W-1:0] bu_rob_idx_i,
    input  logic                        cu_valid_i,
    output redir_src_t                  src_o,
    output logic [NUM_BU-1:0]           bu_gnt_o,
    output logic [IDX_W-1:0]            win_idx_o,
    output logic [ROB_IDX_W-1:0]        win_age_o
);

    logic [ROB_IDX_W-1:0] age;
    logic                 bu_found;
    logic [IDX_W-1:0]     best_idx;
    logic [ROB_IDX_W-1:0] best_age;

    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        age      = '0;
        bu_found = 1'b0;
        best_idx = '0;
        best_age = '0;
        // Strict '<' keeps the earlier (lower-index) port on equal ages.
        for (int i = 0; i < NUM_BU; i++) begin
            age = bu_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W] - rob_head_idx_i;
            if (bu_valid_i[i] && (!bu_found || age < best_age)) begin
                bu_found = 1'b1;
                best_idx = IDX_W'(i);
                best_age = age;
            end
        end

        src_o     = SRC_NONE;
        bu_gnt_o  = '0;
        win_idx_o = best_idx;
        win_age_o = best_age;
        if (cu_valid_i) begin
            src_o     = SRC_CU;
            win_age_o = '0;
        end else if (bu_found) begin
            src_o              = SRC_BU;
            bu_gnt_o[best_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fe_redirect_arb.sv
// Frontend PC-redirect arbiter. Shares the single pcgen redirect port among
// NUM_BU branch units and the commit unit, always forwarding the redirect of
// the oldest in-flight instruction (by ROB index relative to the ROB head).
// A request is held until pcgen accepts it; a strictly older request may
// replace it beforehand. After handoff the arbiter stalls until flush, but a
// strictly older request (e.g. a commit exception) still overrides.
// Optional feature macro: FE_REDIRECT_STATS_EN enables the redirect and
// preemption counters; otherwise both counter outputs are tied to 0.
// Ports:
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   flush_i         : pipeline flush (drops requests, returns to IDLE)
//   rob_head_idx_i  : current ROB head
//   bus             : request / pcgen redirect bus (slave side)
//   issue_mis_o     : one-cycle pulse after each accepted request
//   redir_cnt_o     : redirects handed to pcgen (saturating)
//   preempt_cnt_o   : preemptions in REDIRECT (saturating)
module fe_redirect_arb
    import expipe_pkg::*;
#(
    parameter int NUM_BU    = 2,
    parameter int ROB_IDX_W = 5,
    parameter int XLEN      = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [ROB_IDX_W-1:0] rob_head_idx_i,
    fe_redirect_arb_if.slave     bus,
    output logic                 issue_mis_o,
    output logic [31:0]          redir_cnt_o,
    output logic [31:0]          preempt_cnt_o
);

    localparam int IDX_W = (NUM_BU > 1) ? $clog2(NUM_BU) : 1;
    // Ordering key: 0 for the commit unit, age+1 for branch units, so the
    // commit request is strictly older than any branch-unit request.
    localparam int KEY_W = ROB_IDX_W + 1;

    logic [XLEN-1:0]      bu_pc  [NUM_BU];
    logic [ROB_IDX_W-1:0] bu_idx [NUM_BU];

    for (genvar g = 0; g < NUM_BU; g++) begin : g_unpack
        assign bu_pc[g]  = bus.bu_pc_i[g*XLEN +: XLEN];
        assign bu_idx[g] = bus.bu_rob_idx_i[g*ROB_IDX_W +: ROB_IDX_W];
    end

    redir_src_t           cand_src;
    logic [NUM_BU-1:0]    cand_gnt;
    logic [IDX_W-1:0]     cand_idx;
    logic [ROB_IDX_W-1:0] cand_age;

    oldest_req_sel #(
        .NUM_BU    (NUM_BU),
        .ROB_IDX_W (ROB_IDX_W)
    ) u_sel (
        .rob_head_idx_i (rob_head_idx_i),
        .bu_valid_i     (bus.bu_valid_i),
        .bu_rob_idx_i   (bus.bu_rob_idx_i),
        .cu_valid_i     (bus.cu_valid_i),
        .src_o          (cand_src),
        .bu_gnt_o       (cand_gnt),
        .win_idx_o      (cand_idx),
        .win_age_o      (cand_age)
    );

    redir_arb_state_t     state_q;
    logic                 valid_q;
    logic                 issue_mis_q;
    redir_src_t           lat_src_q;
    logic [ROB_IDX_W-1:0] lat_idx_q;
    logic [XLEN-1:0]      lat_pc_q;

    // The latched age is re-derived each cycle so head movement and index
    // wrap-around are accounted for.
    logic [ROB_IDX_W-1:0] lat_age;
    logic [KEY_W-1:0]     lat_key;
    logic [KEY_W-1:0]     cand_key;
    logic                 cand_older;
    logic                 accept;

    assign lat_age    = lat_idx_q - rob_head_idx_i;
    assign lat_key    = (lat_src_q == SRC_CU) ? '0 : KEY_W'(lat_age) + KEY_W'(1);
    assign cand_key   = (cand_src == SRC_CU) ? '0 : KEY_W'(cand_age) + KEY_W'(1);
    assign cand_older = cand_key < lat_key;

    always_comb begin
        accept = 1'b0;
        if (rst_ni && !flush_i && cand_src != SRC_NONE) begin
            case (state_q)
                IDLE:     accept = 1'b1;
                REDIRECT: accept = !bus.fe_pcgen_ready_i && cand_older;
                STALL:    accept = cand_older;
                default:  accept = 1'b0;
            endcase
        end
    end

    assign bus.bu_ready_o = (accept && cand_src == SRC_BU) ? cand_gnt : '0;
    assign bus.cu_ready_o = accept && cand_src == SRC_CU;

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // every state flop (including the PC latch, which drives an output) is
    // cleared; all state updates use non-blocking assignments.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            issue_mis_q <= 1'b0;
            lat_src_q   <= SRC_NONE;
            lat_idx_q   <= '0;
            lat_pc_q    <= '0;
        end else begin
            issue_mis_q <= accept;
            if (accept) begin
                state_q   <= REDIRECT;
                valid_q   <= 1'b1;
                lat_src_q <= cand_src;
                if (cand_src == SRC_CU) begin
                    lat_idx_q <= '0;
                    lat_pc_q  <= bus.cu_pc_i;
                end else begin
                    lat_idx_q <= bu_idx[cand_idx];
                    lat_pc_q  <= bu_pc[cand_idx];
                end
            end else if (state_q == REDIRECT && bus.fe_pcgen_ready_i) begin
                state_q <= STALL;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.fe_pcgen_valid_o = valid_q;
    assign bus.fe_pcgen_pc_o    = lat_pc_q;
    assign issue_mis_o          = issue_mis_q;

`ifdef FE_REDIRECT_STATS_EN
    logic [31:0] redir_cnt_q;
    logic [31:0] preempt_cnt_q;
    logic        redir_evt;
    logic        preempt_evt;

    // A handoff during a flush cycle does not count: the FSM never reaches STALL.
    assign redir_evt   = state_q == REDIRECT && bus.fe_pcgen_ready_i && !flush_i;
    assign preempt_evt = state_q == REDIRECT && accept;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            redir_cnt_q   <= '0;
            preempt_cnt_q <= '0;
        end else begin
            if (redir_evt && redir_cnt_q != '1) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
            if (preempt_evt && preempt_cnt_q != '1) begin
                preempt_cnt_q <= preempt_cnt_q + 32'd1;
            end
        end
    end

    assign redir_cnt_o   = redir_cnt_q;
    assign preempt_cnt_o = preempt_cnt_q;
`else
    assign redir_cnt_o   = '0;
    assign preempt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fe_redirect_arb.sv
// Self-checking bench for fe_redirect_arb: directed scenarios pinned with
// literal expectations, then randomized traffic compared every cycle
// against a behavioural model of the arbitration rules.
module tb_fe_redirect_arb;

    localparam int NUM_BU    = 2;
    localparam int ROB_IDX_W = 5;
    localparam int XLEN      = 64;
    localparam int MASK      = (1 << ROB_IDX_W) - 1;
    localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;
`ifdef FE_REDIRECT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_REDIR = 1;
    localparam int M_STALL = 2;

    logic                 clk;
    logic                 rst_ni;
    logic                 flush;
    logic [ROB_IDX_W-1:0] head;
    logic                 issue_mis;
    logic [31:0]          redir_cnt;
    logic [31:0]          preempt_cnt;

    fe_redirect_arb_if #(.NUM_BU(NUM_BU), .ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)) bus ();

    fe_redirect_arb #(.NUM_BU(NUM_BU), .ROB_IDX_W(ROB_IDX_W), .XLEN(XLEN)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush),
        .rob_head_idx_i (head),
        .bus            (bus),
        .issue_mis_o    (issue_mis),
        .redir_cnt_o    (redir_cnt),
        .preempt_cnt_o  (preempt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state.
    int              m_st;
    bit              m_lat_cu;
    int              m_lat_idx;
    logic [63:0]     m_pc;
    bit              m_mis;
    longint unsigned m_redir;
    longint unsigned m_pre;

    logic [1:0]  r_bu;
    logic        r_cu;
    logic        r_v;
    logic [63:0] r_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_st      = M_IDLE;
        m_lat_cu  = 1'b0;
        m_lat_idx = 0;
        m_pc      = '0;
        m_mis     = 1'b0;
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic step(input bit rst_n, input bit fl, input int hd, input bit [1:0] bv,
                        input int i0, input int i1, input logic [63:0] p0, input logic [63:0] p1,
                        input bit cv, input logic [63:0] cpc, input bit pr,
                        output logic [1:0] o_bu, output logic o_cu, output logic o_v,
                        output logic [63:0] o_pc);
        int          idx [NUM_BU];
        logic [63:0] pcs [NUM_BU];
        bit          c_valid;
        bit          c_cu;
        int          c_port;
        int          c_key;
        int          lk;
        int          k;
        bit          acc;
        logic [1:0]  e_bu;
        logic [4:0]  a0;
        logic [4:0]  a1;

        idx[0] = i0; idx[1] = i1;
        pcs[0] = p0; pcs[1] = p1;
        a0 = i0[4:0]; a1 = i1[4:0];

        rst_ni               = rst_n;
        flush                = fl;
        head                 = hd[ROB_IDX_W-1:0];
        bus.bu_valid_i       = bv;
        bus.bu_rob_idx_i     = {a1, a0};
        bus.bu_pc_i          = {p1, p0};
        bus.cu_valid_i       = cv;
        bus.cu_pc_i          = cpc;
        bus.fe_pcgen_ready_i = pr;

        @(negedge clk);

        // Oldest valid request: commit first, else smallest age, lowest port.
        c_valid = 1'b0; c_cu = 1'b0; c_port = 0; c_key = 0;
        if (cv) begin
            c_valid = 1'b1; c_cu = 1'b1; c_key = 0;
        end else begin
            for (int p = 0; p < NUM_BU; p++) begin
                k = ((idx[p] - hd) & MASK) + 1;
                if (bv[p] && (!c_valid || k < c_key)) begin
                    c_valid = 1'b1; c_port = p; c_key = k;
                end
            end
        end
        lk  = m_lat_cu ? 0 : ((m_lat_idx - hd) & MASK) + 1;
        acc = rst_n && !fl && c_valid &&
              (m_st == M_IDLE || (m_st == M_REDIR && !pr && c_key < lk) ||
               (m_st == M_STALL && c_key < lk));
        e_bu = (acc && !c_cu) ? 2'(1 << c_port) : 2'b00;

        o_bu = bus.bu_ready_o;
        o_cu = bus.cu_ready_o;
        o_v  = bus.fe_pcgen_valid_o;
        o_pc = bus.fe_pcgen_pc_o;

        check("bu_ready",    {62'd0, bus.bu_ready_o},     {62'd0, e_bu});
        check("cu_ready",    {63'd0, bus.cu_ready_o},     {63'd0, acc && c_cu});
        check("pcgen_valid", {63'd0, bus.fe_pcgen_valid_o}, {63'd0, m_st == M_REDIR});
        check("pcgen_pc",    bus.fe_pcgen_pc_o,           m_pc);
        check("issue_mis",   {63'd0, issue_mis},          {63'd0, m_mis});
        check("redir_cnt",   {32'd0, redir_cnt},          m_redir);
        check("preempt_cnt", {32'd0, preempt_cnt},        m_pre);

        if (!rst_n) begin
            model_clear();
            m_redir = 0;
            m_pre   = 0;
        end else if (fl) begin
            model_clear();
        end else begin
            m_mis = acc;
            if (m_st == M_REDIR && pr) begin
                m_st = M_STALL;
                if (STATS && m_redir < CNT_MAX) m_redir++;
            end else if (acc) begin
                if (STATS && m_st == M_REDIR && m_pre < CNT_MAX) m_pre++;
                m_st      = M_REDIR;
                m_lat_cu  = c_cu;
                m_lat_idx = c_cu ? 0 : idx[c_port];
                m_pc      = c_cu ? cpc : pcs[c_port];
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 0, 2'b00, 0, 0, '0, '0, 1'b0, '0, 1'b0, r_bu, r_cu, r_v, r_pc);
    endtask

    task automatic idle(input int hd, input bit pr);
        step(1'b1, 1'b0, hd, 2'b00, 0, 0, '0, '0, 1'b0, '0, pr, r_bu, r_cu, r_v, r_pc);
    endtask

    initial begin
        rst_ni = 1'b0; flush = 1'b0; head = '0;
        bus.bu_valid_i = '0; bus.bu_rob_idx_i = '0; bus.bu_pc_i = '0;
        bus.cu_valid_i = 1'b0; bus.cu_pc_i = '0; bus.fe_pcgen_ready_i = 1'b0;
        model_clear();
        m_redir = 0;
        m_pre   = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        do_reset();
        check("rst_valid", {63'd0, r_v}, 64'd0);
        check("rst_pc", r_pc, 64'd0);

        // 1: single request, handoff at t+1, STALL at t+2.
        step(1'b1, 1'b0, 0, 2'b01, 4, 0, 64'h100, '0, 1'b0, '0, 1'b0, r_bu, r_cu, r_v, r_pc);
        check("t1_bu_ready", {62'd0, r_bu}, 64'd1);
        idle(0, 1'b1);
        check("t1_valid", {63'd0, r_v}, 64'd1);
        check("t1_pc", r_pc, 64'h100);
        idle(0, 1'b0);
        check("t1_stall_valid", {63'd0, r_v}, 64'd0);

        // 2: simultaneous requests, BU1 is older.
        do_reset();
        step(1'b1, 1'b0, 0, 2'b11, 9, 3, 64'h900, 64'h300, 1'b0, '0, 1'b0, r_bu, r_cu, r_v, r_pc);
        check("t2_bu_ready", {62'd0, r_bu}, 64'd2);
        idle(0, 1'b0);
        check("t2_pc", r_pc, 64'h300);

        // 3: commit request preempts a pending BU redirect.
        do_reset();
        step(1'b1, 1'b0, 0, 2'b01, 7, 0, 64'h700, '0, 1'b0, '0, 1'b0, r_bu, r_cu, r_v, r_pc);
        step(1'b1, 1'b0, 0, 2'b00, 0, 0, '0, '0, 1'b1, 64'h80, 1'b0, r_bu, r_cu, r_v, r_pc);
        check("t3_cu_ready", {63'd0, r_cu}, 64'd1);
        check("t3_old_pc", r_pc, 64'h700);
        idle(0, 1'b0);
        check("t3_new_pc", r_pc, 64'h80);
        check("t3_preempt_cnt", {32'd0, preempt_cnt}, STATS ? 64'd1 : 64'd0);

        // 4: wrap-around ages with head=30.
        do_reset();
        step(1'b1, 1'b0, 30, 2'b11, 1, 31, 64'h10, 64'h1F0, 1'b0, '0, 1'b0, r_bu, r_cu, r_v, r_pc);
        check("t4_bu_ready", {62'd0, r_bu}, 64'd2);

        // 5: flush in STALL drops the request; flush in REDIRECT keeps valid that cycle.
        do_reset();
        step(1'b1, 1'b0, 0, 2'b01, 2, 0, 64'h200, '0, 1'b0, '0, 1'b0, r_bu, r_cu, r_v, r_pc);
        idle(0, 1'b1);
        step(1'b1, 1'b1, 0, 2'b01, 1, 0, 64'h210, '0, 1'b0, '0, 1'b0, r_bu, r_cu, r_v, r_pc);
        check("t5_flush_bu_ready", {62'd0, r_bu}, 64'd0);
        idle(0, 1'b0);
        check("t5_after_flush_valid", {63'd0, r_v}, 64'd0);
        step(1'b1, 1'b0, 0, 2'b01, 3, 0, 64'h300, '0, 1'b0, '0, 1'b0, r_bu, r_cu, r_v, r_pc);
        step(1'b1, 1'b1, 0, 2'b00, 0, 0, '0, '0, 1'b0, '0, 1'b0, r_bu, r_cu, r_v, r_pc);
        check("t5_flush_redirect_valid", {63'd0, r_v}, 64'd1);
        idle(0, 1'b0);
        check("t5_flush_drop_valid", {63'd0, r_v}, 64'd0);

        // 6: commit overrides a delivered misprediction; younger BU is then refused.
        do_reset();
        step(1'b1, 1'b0, 0, 2'b01, 6, 0, 64'h600, '0, 1'b0, '0, 1'b0, r_bu, r_cu, r_v, r_pc);
        idle(0, 1'b1);
        step(1'b1, 1'b0, 0, 2'b00, 0, 0, '0, '0, 1'b1, 64'h44, 1'b0, r_bu, r_cu, r_v, r_pc);
        check("t6_cu_ready", {63'd0, r_cu}, 64'd1);
        idle(0, 1'b1);
        check("t6_redirect_valid", {63'd0, r_v}, 64'd1);
        check("t6_redirect_pc", r_pc, 64'h44);
        step(1'b1, 1'b0, 0, 2'b01, 8, 0, 64'h800, '0, 1'b0, '0, 1'b0, r_bu, r_cu, r_v, r_pc);
        check("t6_bu_refused", {62'd0, r_bu}, 64'd0);
        check("t6_stall_valid", {63'd0, r_v}, 64'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 99) >= 2,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, MASK),
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, MASK),
                 $urandom_range(0, MASK),
                 {$urandom(), $urandom()},
                 {$urandom(), $urandom()},
                 $urandom_range(0, 99) < 10,
                 {$urandom(), $urandom()},
                 $urandom_range(0, 99) < 30,
                 r_bu, r_cu, r_v, r_pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
